// File: rtl/icpit_pkg.sv
// ============================================================================
// Module   : icpit_pkg
// Purpose  : Register map, claim-word layout and control-register type for
//            the ICPIT interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package icpit_pkg;

  localparam logic [7:0] MASK_OFF   = 8'h00;
  localparam logic [7:0] PEND_OFF   = 8'h04;
  localparam logic [7:0] CTRL_OFF   = 8'h08;
  localparam logic [7:0] CLAIM_OFF  = 8'h0C;
  localparam logic [7:0] EOI_OFF    = 8'h10;
  localparam logic [7:0] INSERV_OFF = 8'h14;

  localparam int CLAIM_VALID_BIT = 31;

  typedef struct packed {
    logic rotate;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/icpit_prio_arb.sv
// ============================================================================
// Module   : icpit_prio_arb
// Purpose  : Combinational find-first-set arbiter, scanning upward from a
//            start pointer with wrap (rotate=1) or from index 0 (rotate=0).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icpit_prio_arb #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               rotate,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0]    w_base;
  logic [NUM_IRQ-1:0] w_win;
  logic [NUM_IRQ-1:0] w_lsb;
  logic [ID_W-1:0]    w_acc [0:NUM_IRQ];
  logic [ID_W:0]      w_sum;

  assign w_base = rotate ? ptr : '0;

  // Rotate the request vector so the start pointer lands on bit 0, then
  // isolate the lowest set bit; its offset is added back to the pointer.
  assign w_win = NUM_IRQ'({req, req} >> w_base);
  assign w_lsb = w_win & (~w_win + NUM_IRQ'(1));

  assign w_acc[0] = '0;
  for (genvar j = 0; j < NUM_IRQ; j++) begin : g_enc
    assign w_acc[j+1] = w_acc[j] | (w_lsb[j] ? ID_W'(j) : '0);
  end

  assign w_sum = {1'b0, w_base} + {1'b0, w_acc[NUM_IRQ]};
  assign id    = (w_sum >= (ID_W+1)'(NUM_IRQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_IRQ))
                                               : w_sum[ID_W-1:0];
  assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/icpit_irq_ctrl.sv
// ============================================================================
// Module   : icpit_irq_ctrl
// Purpose  : APB interrupt controller: synchronised edge capture, mask,
//            fixed/rotating priority, claim/EOI servicing, single CPU IRQ.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icpit_irq_ctrl
  import icpit_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ADDR_W  = 8
) (
  input  logic               PCLK,
  input  logic               PRESETN,
  input  logic [ADDR_W-1:0]  PADDR,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [31:0]        PWDATA,
  output logic [31:0]        PRDATA,
  output logic               PREADY,
  input  logic [NUM_IRQ-1:0] IREQ,
  output logic               IRQ
);

  localparam int ID_W = $clog2(NUM_IRQ);

  localparam logic [ADDR_W-1:0] c_a_mask   = ADDR_W'(MASK_OFF);
  localparam logic [ADDR_W-1:0] c_a_pend   = ADDR_W'(PEND_OFF);
  localparam logic [ADDR_W-1:0] c_a_ctrl   = ADDR_W'(CTRL_OFF);
  localparam logic [ADDR_W-1:0] c_a_claim  = ADDR_W'(CLAIM_OFF);
  localparam logic [ADDR_W-1:0] c_a_eoi    = ADDR_W'(EOI_OFF);
  localparam logic [ADDR_W-1:0] c_a_inserv = ADDR_W'(INSERV_OFF);

  logic [NUM_IRQ-1:0] r_sync1, r_sync2, r_edge;
  logic [NUM_IRQ-1:0] r_mask, r_pend, r_inserv;
  ctrl_t              r_ctrl;
  logic [ID_W-1:0]    r_rr_ptr;
  logic               r_irq;

  logic [ADDR_W-1:0]  w_addr;
  logic               w_wr, w_rd, w_claim, w_eoi_ok;
  logic [NUM_IRQ-1:0] w_rise, w_elig;
  logic               w_win_valid;
  logic [ID_W-1:0]    w_win_id, w_eoi_id, w_eoi_next;
  logic [ID_W:0]      w_eoi_inc;
  logic [NUM_IRQ-1:0] w_mask_n, w_pend_n, w_inserv_n;
  ctrl_t              w_ctrl_n;
  logic [ID_W-1:0]    w_ptr_n;
  logic               w_irq_n;
  logic               w_unused;

  assign w_addr   = {PADDR[ADDR_W-1:2], 2'b00};
  assign w_wr     = PSEL & PENABLE & PWRITE;
  assign w_rd     = PSEL & PENABLE & ~PWRITE;
  assign w_rise   = r_sync2 & ~r_edge;
  assign w_elig   = r_pend & r_mask;
  assign PREADY   = 1'b1;
  assign IRQ      = r_irq;
  assign w_unused = &{1'b0, PADDR[1:0], PWDATA};

  icpit_prio_arb #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req    (w_elig),
    .ptr    (r_rr_ptr),
    .rotate (r_ctrl.rotate),
    .valid  (w_win_valid),
    .id     (w_win_id)
  );

  assign w_claim    = w_rd && (w_addr == c_a_claim) && (r_inserv == '0) && w_win_valid;
  assign w_eoi_id   = PWDATA[ID_W-1:0];
  assign w_eoi_ok   = ({1'b0, w_eoi_id} < (ID_W+1)'(NUM_IRQ)) && r_inserv[w_eoi_id];
  assign w_eoi_inc  = {1'b0, w_eoi_id} + (ID_W+1)'(1);
  assign w_eoi_next = (w_eoi_inc == (ID_W+1)'(NUM_IRQ)) ? '0 : w_eoi_inc[ID_W-1:0];

  always_comb begin
    w_mask_n   = r_mask;
    w_pend_n   = r_pend;
    w_inserv_n = r_inserv;
    w_ctrl_n   = r_ctrl;
    w_ptr_n    = r_rr_ptr;
    if (w_wr) begin
      case (w_addr)
        c_a_mask: w_mask_n = PWDATA[NUM_IRQ-1:0];
        c_a_pend: w_pend_n = r_pend & ~PWDATA[NUM_IRQ-1:0];
        c_a_ctrl: w_ctrl_n.rotate = PWDATA[0];
        c_a_eoi: begin
          if (w_eoi_ok) begin
            w_inserv_n[w_eoi_id] = 1'b0;
            if (r_ctrl.rotate) w_ptr_n = w_eoi_next;
          end
        end
        default: ;
      endcase
    end
    if (w_claim) begin
      w_pend_n[w_win_id]   = 1'b0;
      w_inserv_n[w_win_id] = 1'b1;
    end
    // New edges are merged last so they survive a same-cycle W1C or claim.
    w_pend_n = w_pend_n | w_rise;
  end

  assign w_irq_n = (|(w_pend_n & w_mask_n)) && (w_inserv_n == '0);

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_edge   <= '0;
      r_mask   <= '0;
      r_pend   <= '0;
      r_inserv <= '0;
      r_ctrl   <= '0;
      r_rr_ptr <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_sync1  <= IREQ;
      r_sync2  <= r_sync1;
      r_edge   <= r_sync2;
      r_mask   <= w_mask_n;
      r_pend   <= w_pend_n;
      r_inserv <= w_inserv_n;
      r_ctrl   <= w_ctrl_n;
      r_rr_ptr <= w_ptr_n;
      r_irq    <= w_irq_n;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      case (w_addr)
        c_a_mask:   PRDATA = 32'(r_mask);
        c_a_pend:   PRDATA = 32'(r_pend);
        c_a_ctrl:   PRDATA = {31'b0, r_ctrl.rotate};
        c_a_inserv: PRDATA = 32'(r_inserv);
        c_a_claim: begin
          if ((r_inserv == '0) && w_win_valid) begin
            PRDATA[CLAIM_VALID_BIT] = 1'b1;
            PRDATA[ID_W-1:0]        = w_win_id;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_icpit_irq_ctrl.sv
// ============================================================================
// Module   : tb_icpit_irq_ctrl
// Purpose  : Randomised APB/IREQ stimulus against a behavioural model of the
//            ICPIT interrupt controller, plus directed boundary scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icpit_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic [7:0]  ireq = '0;
  logic        irq;

  always #5 clk = ~clk;

  icpit_irq_ctrl #(.NUM_IRQ(8), .ADDR_W(8)) dut (
    .PCLK(clk), .PRESETN(rst_n), .PADDR(paddr), .PSEL(psel), .PENABLE(penable),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .IREQ(ireq), .IRQ(irq)
  );

  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_rdata;
  bit          rand_ireq = 0;

  // Behavioural model state
  logic [7:0] m_mask, m_pend, m_inserv, m_ireq_old;
  bit         m_rotate, m_irq;
  int         m_ptr;
  logic [7:0] rq[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_winner();
    logic [7:0] e = m_pend & m_mask;
    int start = m_rotate ? m_ptr : 0;
    for (int k = 0; k < 8; k++) begin
      int i = (start + k) % 8;
      if (e[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] addr);
    int w = m_winner();
    case (addr & 8'hFC)
      8'h00: return {24'b0, m_mask};
      8'h04: return {24'b0, m_pend};
      8'h08: return {31'b0, m_rotate};
      8'h0C: return (m_inserv == 0 && w >= 0) ? (32'h8000_0000 | w) : 32'h0;
      8'h14: return {24'b0, m_inserv};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mask = 0; m_pend = 0; m_inserv = 0; m_rotate = 0; m_ptr = 0; m_irq = 0;
    m_ireq_old = 0;
    rq = {8'h00, 8'h00};
  endtask

  task automatic model_edge();
    logic [7:0] a = paddr & 8'hFC;
    int w = m_winner();
    int id;
    if (psel && penable && !pwrite && a == 8'h0C && m_inserv == 0 && w >= 0) begin
      m_pend[w] = 1'b0;
      m_inserv[w] = 1'b1;
    end
    if (psel && penable && pwrite) begin
      case (a)
        8'h00: m_mask = pwdata[7:0];
        8'h04: m_pend = m_pend & ~pwdata[7:0];
        8'h08: m_rotate = pwdata[0];
        8'h10: begin
          id = int'(pwdata[2:0]);
          if (m_inserv[id]) begin
            m_inserv[id] = 1'b0;
            if (m_rotate) m_ptr = (id + 1) % 8;
          end
        end
        default: ;
      endcase
    end
    m_pend = m_pend | rq.pop_front();
    m_irq = ((m_pend & m_mask) != 0) && (m_inserv == 0);
  endtask

  // One clock: inputs were driven at the preceding negedge.
  task automatic step();
    if (rand_ireq && $urandom_range(0, 2) == 0) begin
      int b = $urandom_range(0, 7);
      ireq[b] = ~ireq[b];
    end
    rq.push_back(ireq & ~m_ireq_old);
    m_ireq_old = ireq;
    #1;
    last_rdata = prdata;
    if (psel && penable && !pwrite) check_eq("prdata", prdata, m_read(paddr));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] data);
    psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
    step();
    penable = 1;
    step();
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; ireq = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    check_eq("rst_irq", {31'b0, irq}, 32'h0);
    check_eq("pready", {31'b0, pready}, 32'h1);
    apb(0, 8'h0C, 0);
    check_eq("rst_claim", last_rdata, 32'h0);

    // Single edge through the synchroniser, then claim
    apb(1, 8'h00, 32'h05);
    ireq = 8'h04;
    idle(3);
    check_eq("t1_irq", {31'b0, irq}, 32'h1);
    ireq = 8'h00;
    apb(0, 8'h04, 0);
    check_eq("t1_pend", last_rdata, 32'h4);
    apb(0, 8'h0C, 0);
    check_eq("t1_claim", last_rdata, 32'h8000_0002);
    check_eq("t1_irq_off", {31'b0, irq}, 32'h0);

    // W1C racing a new edge on the same bit, with that bit masked
    do_reset();
    ireq = 8'h08;
    idle(1);
    apb(1, 8'h04, 32'h08);
    ireq = 8'h00;
    apb(0, 8'h04, 0);
    check_eq("t5_pend", last_rdata, 32'h8);
    check_eq("t5_irq", {31'b0, irq}, 32'h0);

    // Randomised traffic
    do_reset();
    rand_ireq = 1;
    for (int n = 0; n < 1500; n++) begin
      int op = $urandom_range(0, 9);
      logic [31:0] d = $urandom;
      case (op)
        0, 1, 2: apb(0, 8'h0C | 8'($urandom_range(0, 3)), 0);
        3: apb(0, 8'($urandom_range(0, 5) * 4), 0);
        4, 5: begin
          if (m_inserv != 0 && $urandom_range(0, 3) != 0)
            for (int i = 0; i < 8; i++) if (m_inserv[i]) d[2:0] = 3'(i);
          apb(1, 8'h10, d);
        end
        6: apb(1, 8'h00, $urandom_range(0, 1) ? 32'hFF : d);
        7: apb(1, 8'h04, d);
        8: apb(1, 8'h08, d);
        default: begin
          if ($urandom_range(0, 1)) apb(1, {6'($urandom_range(6, 63)), 2'b00}, d);
          else apb(0, {6'($urandom_range(6, 63)), 2'b00}, 0);
          idle($urandom_range(0, 3));
        end
      endcase
    end
    rand_ireq = 0;
    ireq = 0;
    idle(4);

    // Reset asserted during the access phase of a claim
    apb(1, 8'h00, 32'hFF);
    ireq = 8'h01;
    idle(3);
    ireq = 8'h00;
    psel = 1; penable = 0; pwrite = 0; paddr = 8'h0C;
    step();
    penable = 1;
    #3 rst_n = 0;
    #1 check_eq("rst_mid_prdata", prdata, 32'h0);
    psel = 0; penable = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_eq("rst_mid_irq", {31'b0, irq}, 32'h0);
    apb(0, 8'h00, 0);
    check_eq("rst_mid_mask", last_rdata, 32'h0);
    apb(0, 8'h04, 0);
    check_eq("rst_mid_pend", last_rdata, 32'h0);
    apb(0, 8'h14, 0);
    check_eq("rst_mid_inserv", last_rdata, 32'h0);
    apb(0, 8'h0C, 0);
    check_eq("rst_mid_claim", last_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
